// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the I/D memory port arbiter: FSM states, owner tag, latched memory request.
// Field widths match the arbiter's default 32-bit address/data configuration.
package mem_port_arbiter_pkg;

  localparam int MP_ADDR_W = 32;
  localparam int MP_DATA_W = 32;
  localparam int MP_BE_W   = MP_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  typedef struct packed {
    logic                 we;
    logic [MP_BE_W-1:0]   be;
    logic [MP_ADDR_W-1:0] addr;
    logic [MP_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_timeout_ctr.sv
// Watchdog for the WAIT state: counts while enabled, flags expiry at TIMEOUT-1.
// Zero latency on the flag (combinational compare); no backpressure, saturates at expiry.
module arb_timeout_ctr #(
  parameter int TIMEOUT = 64
) (
  input  logic CLOCK,
  input  logic RESET_N,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] cnt_q;

  assign expired = en && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch (I) and load/store (D) onto one memory port, one transaction in flight.
// REQ->GNT same cycle, M_REQ next cycle, >=4 cycles/txn; ISSUE holds until M_GNT, WAIT bounded by watchdog.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W    = MP_ADDR_W,
  parameter int DATA_W    = MP_DATA_W,
  parameter bit DATA_PRIO = 1'b1,
  parameter int TIMEOUT   = 64
) (
  input  logic                CLOCK,
  input  logic                RESET_N,
  input  logic                I_REQ,
  input  logic [ADDR_W-1:0]   I_ADDR,
  output logic                I_GNT,
  output logic                I_RVALID,
  output logic [DATA_W-1:0]   I_RDATA,
  output logic                I_ERR,
  input  logic                D_REQ,
  input  logic                D_WE,
  input  logic [DATA_W/8-1:0] D_BE,
  input  logic [ADDR_W-1:0]   D_ADDR,
  input  logic [DATA_W-1:0]   D_WDATA,
  output logic                D_GNT,
  output logic                D_RVALID,
  output logic [DATA_W-1:0]   D_RDATA,
  output logic                D_ERR,
  output logic                M_REQ,
  output logic                M_WE,
  output logic [DATA_W/8-1:0] M_BE,
  output logic [ADDR_W-1:0]   M_ADDR,
  output logic [DATA_W-1:0]   M_WDATA,
  input  logic                M_GNT,
  input  logic                M_RVALID,
  input  logic [DATA_W-1:0]   M_RDATA
);

  arb_state_t        state_q, state_d;
  owner_t            owner_q, last_owner_q, winner;
  mem_req_t          mreq_q, grant_req;
  logic [DATA_W-1:0] i_rdata_q, d_rdata_q, resp_data;
  logic              i_err_q, d_err_q, resp_err;
  logic              is_idle, any_gnt, resp_take, tmo_expired;

  arb_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .clr     (state_q != WAIT),
    .en      (state_q == WAIT),
    .expired (tmo_expired)
  );

  always_comb begin
    winner = OWN_I;
    if (D_REQ && !I_REQ) begin
      winner = OWN_D;
    end else if (D_REQ && I_REQ) begin
      winner = (DATA_PRIO || last_owner_q == OWN_I) ? OWN_D : OWN_I;
    end
  end

  // Reset is folded in so grants are also forced low while RESET_N is held.
  assign is_idle = (state_q == IDLE) && RESET_N;
  assign I_GNT   = is_idle && I_REQ && (winner == OWN_I);
  assign D_GNT   = is_idle && D_REQ && (winner == OWN_D);
  assign any_gnt = I_GNT || D_GNT;

  always_comb begin
    if (winner == OWN_D) begin
      grant_req = '{we: D_WE, be: D_BE, addr: D_ADDR, wdata: D_WDATA};
    end else begin
      grant_req = '{we: 1'b0, be: '1, addr: I_ADDR, wdata: '0};
    end
  end

  // A real response beats a coincident watchdog expiry.
  assign resp_take = (state_q == WAIT) && (M_RVALID || tmo_expired);
  assign resp_data = M_RVALID ? M_RDATA : '0;
  assign resp_err  = !M_RVALID;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (I_REQ || D_REQ) state_d = ISSUE;
      ISSUE: if (M_GNT)          state_d = WAIT;
      WAIT:  if (resp_take)      state_d = RESP;
      RESP:                      state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= IDLE;
      owner_q      <= OWN_I;
      last_owner_q <= OWN_D;
      mreq_q       <= '0;
      i_rdata_q    <= '0;
      i_err_q      <= 1'b0;
      d_rdata_q    <= '0;
      d_err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (any_gnt) begin
        owner_q      <= winner;
        last_owner_q <= winner;
        mreq_q       <= grant_req;
      end
      if (resp_take) begin
        if (owner_q == OWN_I) begin
          i_rdata_q <= resp_data;
          i_err_q   <= resp_err;
        end else begin
          // Store acks carry no data back to the LSU.
          d_rdata_q <= mreq_q.we ? '0 : resp_data;
          d_err_q   <= resp_err;
        end
      end
    end
  end

  assign M_REQ    = (state_q == ISSUE);
  assign M_WE     = mreq_q.we;
  assign M_BE     = mreq_q.be;
  assign M_ADDR   = mreq_q.addr;
  assign M_WDATA  = mreq_q.wdata;

  assign I_RVALID = (state_q == RESP) && (owner_q == OWN_I);
  assign D_RVALID = (state_q == RESP) && (owner_q == OWN_D);
  assign I_RDATA  = i_rdata_q;
  assign I_ERR    = i_err_q;
  assign D_RDATA  = d_rdata_q;
  assign D_ERR    = d_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: two arbiters (D-priority and round-robin) share stimulus, separate REQ lines.
module tb_mem_port_arbiter;

  logic        clk, rst_n;
  logic        i_req, d_req, i_req0, d_req0, d_we;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [3:0]  d_be;
  logic        m_gnt, m_rvalid;

  logic        i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err, m_req, m_we;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic [3:0]  m_be;

  logic        z_i_gnt, z_i_rvalid, z_i_err, z_d_gnt, z_d_rvalid, z_d_err, z_m_req, z_m_we;
  logic [31:0] z_i_rdata, z_d_rdata, z_m_addr, z_m_wdata;
  logic [3:0]  z_m_be;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(.DATA_PRIO(1'b1), .TIMEOUT(64)) u_prio (
    .CLOCK(clk), .RESET_N(rst_n),
    .I_REQ(i_req), .I_ADDR(i_addr), .I_GNT(i_gnt), .I_RVALID(i_rvalid),
    .I_RDATA(i_rdata), .I_ERR(i_err),
    .D_REQ(d_req), .D_WE(d_we), .D_BE(d_be), .D_ADDR(d_addr), .D_WDATA(d_wdata),
    .D_GNT(d_gnt), .D_RVALID(d_rvalid), .D_RDATA(d_rdata), .D_ERR(d_err),
    .M_REQ(m_req), .M_WE(m_we), .M_BE(m_be), .M_ADDR(m_addr), .M_WDATA(m_wdata),
    .M_GNT(m_gnt), .M_RVALID(m_rvalid), .M_RDATA(m_rdata)
  );

  mem_port_arbiter #(.DATA_PRIO(1'b0), .TIMEOUT(64)) u_rr (
    .CLOCK(clk), .RESET_N(rst_n),
    .I_REQ(i_req0), .I_ADDR(i_addr), .I_GNT(z_i_gnt), .I_RVALID(z_i_rvalid),
    .I_RDATA(z_i_rdata), .I_ERR(z_i_err),
    .D_REQ(d_req0), .D_WE(d_we), .D_BE(d_be), .D_ADDR(d_addr), .D_WDATA(d_wdata),
    .D_GNT(z_d_gnt), .D_RVALID(z_d_rvalid), .D_RDATA(z_d_rdata), .D_ERR(z_d_err),
    .M_REQ(z_m_req), .M_WE(z_m_we), .M_BE(z_m_be), .M_ADDR(z_m_addr), .M_WDATA(z_m_wdata),
    .M_GNT(m_gnt), .M_RVALID(m_rvalid), .M_RDATA(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "bench time limit");
  end

  initial begin
    rst_n = 1'b0; i_req = 0; d_req = 0; i_req0 = 0; d_req0 = 0; d_we = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; d_be = 0; m_gnt = 0; m_rvalid = 0; m_rdata = 0;
    #3;
    chk("rst_m_req", m_req, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_be", m_be, 0);
    chk("rst_i_rvalid", i_rvalid, 0);
    chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_i_err", i_err, 0);
    chk("rst_rr_m_req", z_m_req, 0);
    @(negedge clk); rst_n = 1'b1;
    tick;

    // 1: fetch only, memory answers as fast as possible
    i_req = 1; i_addr = 32'h100; #1;
    chk("t1_i_gnt", i_gnt, 1);
    chk("t1_d_gnt", d_gnt, 0);
    chk("t1_m_req_idle", m_req, 0);
    tick; i_req = 0; m_gnt = 1; #1;
    chk("t1_m_req", m_req, 1);
    chk("t1_m_addr", m_addr, 32'h100);
    chk("t1_m_we", m_we, 0);
    chk("t1_m_be", m_be, 4'hF);
    tick; m_gnt = 0; m_rvalid = 1; m_rdata = 32'hDEADBEEF; #1;
    chk("t1_i_rvalid_wait", i_rvalid, 0);
    tick; m_rvalid = 0; #1;
    chk("t1_i_rvalid", i_rvalid, 1);
    chk("t1_i_rdata", i_rdata, 32'hDEADBEEF);
    chk("t1_i_err", i_err, 0);
    chk("t1_d_rvalid", d_rvalid, 0);
    chk("t1_d_rdata", d_rdata, 0);
    tick; #1;
    chk("t1_i_rvalid_pulse", i_rvalid, 0);

    // 2: tie with D priority, D store wins, I served after
    i_req = 1; i_addr = 32'h104;
    d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'h55; d_be = 4'b0001; #1;
    chk("t2_d_gnt", d_gnt, 1);
    chk("t2_i_gnt", i_gnt, 0);
    tick; d_req = 0; m_gnt = 1; #1;
    chk("t2_m_we", m_we, 1);
    chk("t2_m_be", m_be, 4'b0001);
    chk("t2_m_addr", m_addr, 32'h200);
    chk("t2_m_wdata", m_wdata, 32'h55);
    chk("t2_i_gnt_busy", i_gnt, 0);
    tick; m_gnt = 0; m_rvalid = 1; m_rdata = 32'h1234; #1;
    tick; m_rvalid = 0; #1;
    chk("t2_d_rvalid", d_rvalid, 1);
    chk("t2_d_rdata_store", d_rdata, 0);
    chk("t2_i_rvalid", i_rvalid, 0);
    chk("t2_i_gnt_resp", i_gnt, 0);
    tick; #1;
    chk("t2_i_gnt_late", i_gnt, 1);
    chk("t2_m_we_hold", m_we, 1);
    tick; i_req = 0; m_gnt = 1; #1;
    chk("t2_i_m_we", m_we, 0);
    chk("t2_i_m_addr", m_addr, 32'h104);
    chk("t2_i_m_wdata", m_wdata, 0);
    chk("t2_i_m_be", m_be, 4'hF);
    tick; m_gnt = 0; m_rvalid = 1; m_rdata = 32'hCAFEF00D; #1;
    tick; m_rvalid = 0; #1;
    chk("t2_i_rvalid", i_rvalid, 1);
    chk("t2_i_rdata", i_rdata, 32'hCAFEF00D);
    tick;

    // 3: round-robin instance, both held high: I, D, I, D
    d_we = 0; d_be = 4'hF; i_req0 = 1; d_req0 = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t3_i_gnt", z_i_gnt, ((k % 2) == 0) ? 32'd1 : 32'd0);
      chk("t3_d_gnt", z_d_gnt, ((k % 2) == 1) ? 32'd1 : 32'd0);
      tick; m_gnt = 1; #1;
      chk("t3_m_req", z_m_req, 1);
      tick; m_gnt = 0; m_rvalid = 1; m_rdata = 32'hA0 + k;
      tick; m_rvalid = 0; #1;
      if ((k % 2) == 0) chk("t3_i_rdata", z_i_rvalid ? z_i_rdata : 32'hFFFF_FFFF, 32'hA0 + k);
      else              chk("t3_d_rdata", z_d_rvalid ? z_d_rdata : 32'hFFFF_FFFF, 32'hA0 + k);
      tick;
    end
    i_req0 = 0; d_req0 = 0;

    // 4: memory never responds, watchdog forces an error after 64 WAIT cycles
    i_req = 1; i_addr = 32'h300; #1;
    chk("t4_i_gnt", i_gnt, 1);
    tick; i_req = 0; m_gnt = 1;
    tick; m_gnt = 0;
    for (int k = 1; k < 64; k++) begin
      tick;
      chk("t4_no_rvalid", i_rvalid, 0);
    end
    tick;
    chk("t4_i_rvalid", i_rvalid, 1);
    chk("t4_i_err", i_err, 1);
    chk("t4_i_rdata", i_rdata, 0);
    tick;
    chk("t4_i_rvalid_pulse", i_rvalid, 0);

    // 5: M_GNT held off 5 cycles, spurious M_RVALID during ISSUE
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h400; d_wdata = 0; #1;
    chk("t5_d_gnt", d_gnt, 1);
    tick; d_req = 0; d_addr = 32'h999; m_rvalid = 1; m_rdata = 32'hBAD;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t5_m_req", m_req, 1);
      chk("t5_m_addr", m_addr, 32'h400);
      chk("t5_d_rvalid", d_rvalid, 0);
      tick;
    end
    m_rvalid = 0; m_gnt = 1; #1;
    chk("t5_m_req_last", m_req, 1);
    chk("t5_m_addr_last", m_addr, 32'h400);
    tick; m_gnt = 0; #1;
    chk("t5_m_req_wait", m_req, 0);
    chk("t5_d_rvalid_wait", d_rvalid, 0);
    m_rvalid = 1; m_rdata = 32'h600D;
    tick; m_rvalid = 0; #1;
    chk("t5_d_rvalid", d_rvalid, 1);
    chk("t5_d_rdata", d_rdata, 32'h600D);
    chk("t5_d_err", d_err, 0);
    tick;

    // 6: reset asserted mid-WAIT
    i_req = 1; i_addr = 32'h500; #1;
    chk("t6_i_gnt", i_gnt, 1);
    tick; i_req = 0; m_gnt = 1;
    tick; m_gnt = 0; #1;
    chk("t6_m_addr_pre", m_addr, 32'h500);
    rst_n = 1'b0; d_req = 1; #1;
    chk("t6_m_req", m_req, 0);
    chk("t6_m_addr", m_addr, 0);
    chk("t6_m_be", m_be, 0);
    chk("t6_i_err", i_err, 0);
    chk("t6_d_gnt", d_gnt, 0);
    d_req = 0;
    @(negedge clk); rst_n = 1'b1;
    tick; m_rvalid = 1; m_rdata = 32'h777;
    tick; m_rvalid = 0; #1;
    chk("t6_late_i_rvalid", i_rvalid, 0);
    chk("t6_late_d_rvalid", d_rvalid, 0);
    chk("t6_late_m_req", m_req, 0);
    i_req = 1; i_addr = 32'h600; #1;
    chk("t6_regrant", i_gnt, 1);
    tick; i_req = 0; m_gnt = 1; #1;
    chk("t6_m_addr_new", m_addr, 32'h600);
    tick; m_gnt = 0; m_rvalid = 1; m_rdata = 32'h42;
    tick; m_rvalid = 0; #1;
    chk("t6_i_rvalid", i_rvalid, 1);
    chk("t6_i_rdata", i_rdata, 32'h42);
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported memory between the core's instruction-fetch requester (I) and load/store requester (D).
- Each requester has its own req/grant/response handshake.
- The block arbitrates, captures the winning request, issues it on the memory port, and routes the single response back to its owner.
- A watchdog returns an error response if the memory never answers.
- Sits between the RV32I core fetch/LSU logic and the unified memory.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
DATA_PRIO, 1, 1 = D always wins ties; 0 = round-robin between I and D
TIMEOUT, 64, cycles in WAIT without M_RVALID before an error response is forced (must be ≥2)

Ports:
CLOCK  in  1  system clock, rising edge
RESET_N  in  1  asynchronous active-low reset
I_REQ  in  1  fetch request; held with I_ADDR until I_GNT
I_ADDR  in  ADDR_W  fetch address
I_GNT  out  1  fetch request accepted (1-cycle pulse)
I_RVALID  out  1  fetch response valid (1-cycle pulse)
I_RDATA  out  DATA_W  fetch read data
I_ERR  out  1  fetch response is a timeout error
D_REQ  in  1  load/store request; held with payload until D_GNT
D_WE  in  1  1 = store, 0 = load
D_BE  in  DATA_W/8  store byte enables
D_ADDR  in  ADDR_W  load/store address
D_WDATA  in  DATA_W  store data
D_GNT  out  1  load/store accepted (1-cycle pulse)
D_RVALID  out  1  load data / store ack valid (1-cycle pulse)
D_RDATA  out  DATA_W  load data (0 for stores)
D_ERR  out  1  response is a timeout error
M_REQ  out  1  memory request, held until M_GNT
M_WE  out  1  memory write enable
M_BE  out  DATA_W/8  memory byte enables
M_ADDR  out  ADDR_W  memory address
M_WDATA  out  DATA_W  memory write data
M_GNT  in  1  memory accepted request
M_RVALID  in  1  memory response (read data or write ack), exactly one per accepted request
M_RDATA  in  DATA_W  memory read data

Behaviour:

State machine (one transaction outstanding at a time):
- IDLE -> ISSUE, when any REQ is high.
- ISSUE -> WAIT, when M_GNT is high.
- WAIT -> RESP, when M_RVALID is high or the timeout counter reaches TIMEOUT-1.
- RESP -> IDLE, unconditionally.

Arbitration and grant (IDLE only):
- GNT is combinational: X_GNT = X_REQ & winner & (state==IDLE).
- At that edge, latch owner, M_WE, M_BE, M_ADDR, M_WDATA. For I requests the latched values are WE=0, BE=all-ones, WDATA=0.
- Tie, DATA_PRIO=1: D wins.
- Tie, DATA_PRIO=0: the requester that was not the last owner wins. The last-owner flag resets to D, so I wins the first tie.
- The last-owner flag updates on every grant.
- Only one requester is ever granted; the loser keeps REQ high and is served later.

Memory side:
- ISSUE: M_REQ=1 with the latched payload, held stable until M_GNT.
- All other states: M_REQ=0.
- M_WE, M_BE, M_ADDR, M_WDATA hold their last latched values outside ISSUE.

Response capture and routing:
- WAIT: the timeout counter starts at 0 on entry and increments each cycle.
- On M_RVALID: capture M_RDATA and set err=0.
- On timeout: capture data=0 and set err=1.
- RESP: the owner's RVALID=1 for exactly one cycle, with captured RDATA/ERR.
- The non-owner's RVALID stays 0.
- RDATA/ERR may hold stale values when RVALID=0.

Latency and throughput:
- REQ in IDLE at cycle t -> GNT at t -> M_REQ at t+1.
- With M_GNT at t+1 and M_RVALID at t+2, RVALID occurs at t+3.
- Minimum 4 cycles per transaction.

Ignored inputs and fixed rules:
- M_RVALID outside WAIT is ignored.
- M_GNT outside ISSUE is ignored.
- TIMEOUT is counted only in WAIT; ISSUE waits on M_GNT indefinitely.
- M_RVALID and timeout in the same cycle: M_RVALID wins, err=0.
- REQ dropping before GNT is legal; no grant results.

Reset (RESET_N low, asynchronous):
- State=IDLE; all GNT, RVALID, ERR, M_REQ = 0.
- All data/address outputs = 0; counter = 0.
- Reset mid-transaction drops it silently; no response is ever produced for it.

Decomposition:
- Add to typePack:
  - arb_state_t enum (IDLE, ISSUE, WAIT, RESP).
  - owner_t enum (OWN_I, OWN_D).
  - mem_req_t packed struct (we, be, addr, wdata).
- One natural sub-module, arb_timeout_ctr: clear/enable/expire flag, parameterised by TIMEOUT.
- Priority selection stays inline.

Test Plan:
1. I only, I_ADDR=0x100. Memory: M_GNT same cycle, M_RVALID next with 0xDEADBEEF. Expect: I_GNT at t; I_RVALID at t+3 with I_RDATA=0xDEADBEEF, I_ERR=0; D_* stay 0.
2. Tie, DATA_PRIO=1. Both request at t (D: store 0x200, WDATA 0x55, BE 0001). Expect: D granted at t, M_WE=1 M_BE=0001; I granted at the first IDLE after D_RVALID.
3. DATA_PRIO=0, both held high for 4 transactions. Expect grant order I, D, I, D.
4. Memory never asserts M_RVALID, TIMEOUT=64. Expect owner RVALID=1 with ERR=1, RDATA=0, exactly 64 cycles after entering WAIT.
5. M_GNT delayed 5 cycles. Expect M_REQ and payload stable for all 6 cycles; spurious M_RVALID during ISSUE has no effect.
6. RESET_N low while in WAIT. Expect all outputs 0 immediately, with no clock edge needed. After release, a late M_RVALID produces no RVALID and the next REQ is granted normally.
